// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer.
//   STORE_BUFFER_DEPTH   entry count used by the top-level instantiation
//   STORE_BUFFER_ADDR_W  byte-address width of a buffered store
//   STORE_BUFFER_DATA_W  data width of a buffered store (multiple of 8)
//   store_buffer_entry_t one queued store {addr, data, mask}
//   byte_off_w()         number of byte-offset address bits for a data width
package store_buffer_pkg;

  localparam int unsigned STORE_BUFFER_DEPTH  = 4;
  localparam int unsigned STORE_BUFFER_ADDR_W = 32;
  localparam int unsigned STORE_BUFFER_DATA_W = 32;

  typedef struct packed {
    logic [STORE_BUFFER_ADDR_W-1:0]   addr;
    logic [STORE_BUFFER_DATA_W-1:0]   data;
    logic [STORE_BUFFER_DATA_W/8-1:0] mask;
  } store_buffer_entry_t;

  // Address bits below this index select a byte within one data word.
  function automatic int unsigned byte_off_w(input int unsigned data_w);
    return (data_w <= 8) ? 0 : $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/onehot_ring_pointer.sv
// One-hot ring pointer.
//   clock      system clock
//   reset      asynchronous, active-high; pointer returns to bit 0
//   advance_i  rotate the pointer left by one, wrapping bit Depth-1 to bit 0
//   ptr_o      current one-hot pointer
module onehot_ring_pointer #(
  parameter int unsigned Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance_i,
  output logic [Depth-1:0] ptr_o
);

  logic [Depth-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = {ptr_q[Depth-2:0], ptr_q[Depth-1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= Depth'(1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between commit and the data-memory port.
//   clock, reset             system clock, asynchronous active-high reset
//   push_*                   commit-side store input (valid/ready)
//   drain_*                  memory-side head entry output (valid/ready)
//   fwd_addr/hit/data/mask   same-cycle store-to-load forwarding lookup
//   occupancy                one-hot entry count (bit k set => k entries)
//   full, empty              occupancy[DEPTH], occupancy[0]
// ADDR_W and DATA_W must match the widths of store_buffer_entry_t.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = STORE_BUFFER_DEPTH,
  parameter int unsigned ADDR_W = STORE_BUFFER_ADDR_W,
  parameter int unsigned DATA_W = STORE_BUFFER_DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [ADDR_W-1:0]   push_addr,
  input  logic [DATA_W-1:0]   push_data,
  input  logic [DATA_W/8-1:0] push_mask,
  output logic                drain_valid,
  input  logic                drain_ready,
  output logic [ADDR_W-1:0]   drain_addr,
  output logic [DATA_W-1:0]   drain_data,
  output logic [DATA_W/8-1:0] drain_mask,
  input  logic [ADDR_W-1:0]   fwd_addr,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data,
  output logic [DATA_W/8-1:0] fwd_mask,
  output logic [DEPTH:0]      occupancy,
  output logic                full,
  output logic                empty
);

  localparam int unsigned OffW = byte_off_w(DATA_W);
  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [DEPTH-1:0]    head, tail;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH:0]      occ_q, occ_d;
  logic                push_fire, pop_fire;
  store_buffer_entry_t entries_q [DEPTH];
  store_buffer_entry_t head_entry, fwd_entry;
  int unsigned         tail_idx;
  logic [IdxW-1:0]     scan_idx [DEPTH];

  assign full        = occ_q[DEPTH];
  assign empty       = occ_q[0];
  assign occupancy   = occ_q;
  // No same-cycle replace when full, even if the head drains this cycle.
  assign push_ready  = ~full;
  assign drain_valid = ~empty;
  assign push_fire   = push_valid & push_ready;
  assign pop_fire    = drain_valid & drain_ready;

  onehot_ring_pointer #(.Depth(DEPTH)) u_head (
    .clock     (clock),
    .reset     (reset),
    .advance_i (pop_fire),
    .ptr_o     (head)
  );

  onehot_ring_pointer #(.Depth(DEPTH)) u_tail (
    .clock     (clock),
    .reset     (reset),
    .advance_i (push_fire),
    .ptr_o     (tail)
  );

  // Push and pop never address the same entry: a pop needs a non-empty
  // buffer, and then tail != head unless full, where push is blocked.
  always_comb begin
    valid_d = valid_q;
    if (pop_fire)  valid_d = valid_d & ~head;
    if (push_fire) valid_d = valid_d | tail;
  end

  always_comb begin
    occ_d = occ_q;
    case ({push_fire, pop_fire})
      2'b10:   occ_d = {occ_q[DEPTH-1:0], 1'b0};
      2'b01:   occ_d = {1'b0, occ_q[DEPTH:1]};
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= (DEPTH+1)'(1);
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Payload is not reset; valid_q qualifies every use of it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_fire && tail[i]) begin
        entries_q[i] <= '{addr: push_addr, data: push_data, mask: push_mask};
      end
    end
  end

  always_comb begin
    head_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (head[i]) head_entry = entries_q[i];
    end
  end

  assign drain_addr = head_entry.addr;
  assign drain_data = head_entry.data;
  assign drain_mask = head_entry.mask;

  // scan_idx[0] is the youngest slot (tail-1), scan_idx[DEPTH-1] the oldest.
  always_comb begin
    tail_idx = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tail[i]) tail_idx = i;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx[k] = IdxW'((tail_idx + DEPTH - 1 - k) % DEPTH);
    end
  end

  // First valid word-address match in youngest-first order wins.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_entry = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!fwd_hit && valid_q[scan_idx[k]] &&
          entries_q[scan_idx[k]].addr[ADDR_W-1:OffW] == fwd_addr[ADDR_W-1:OffW]) begin
        fwd_hit   = 1'b1;
        fwd_entry = entries_q[scan_idx[k]];
      end
    end
  end

  assign fwd_data = fwd_entry.data;
  assign fwd_mask = fwd_entry.mask;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, 32-bit address/data).
module tb_store_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        push_valid, push_ready;
  logic [31:0] push_addr, push_data;
  logic [3:0]  push_mask;
  logic        drain_valid, drain_ready;
  logic [31:0] drain_addr, drain_data;
  logic [3:0]  drain_mask;
  logic [31:0] fwd_addr, fwd_data;
  logic        fwd_hit;
  logic [3:0]  fwd_mask;
  logic [4:0]  occupancy;
  logic        full, empty;

  int total = 0;
  int bad   = 0;

  logic [31:0] wrap_order [3];

  always #5 clock = ~clock;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .push_mask   (push_mask),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready),
    .drain_addr  (drain_addr),
    .drain_data  (drain_data),
    .drain_mask  (drain_mask),
    .fwd_addr    (fwd_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .fwd_mask    (fwd_mask),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
    push_valid = v;
    push_addr  = a;
    push_data  = d;
    push_mask  = m;
  endtask

  initial begin
    reset = 1'b1;
    set_push(1'b0, 32'h0, 32'h0, 4'h0);
    drain_ready = 1'b0;
    fwd_addr    = 32'h0;
    wrap_order[0] = 32'h1008;
    wrap_order[1] = 32'h100C;
    wrap_order[2] = 32'h3000;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clock);
    check("rst_occ", occupancy, 5'b00001);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_push_ready", push_ready, 1'b1);
    check("rst_drain_valid", drain_valid, 1'b0);
    check("rst_fwd_hit", fwd_hit, 1'b0);

    // Fill to full with drain stalled.
    step();
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      step();
    end
    push_valid = 1'b0;
    #1;
    check("fill_occ", occupancy, 5'b10000);
    check("fill_full", full, 1'b1);
    check("fill_push_ready", push_ready, 1'b0);
    check("fill_drain_valid", drain_valid, 1'b1);
    check("fill_drain_addr", drain_addr, 32'h1000);
    check("fill_drain_data", drain_data, 32'hA0);

    // Push while full is ignored.
    set_push(1'b1, 32'h2000, 32'hEE, 4'hF);
    step();
    push_valid = 1'b0;
    fwd_addr   = 32'h2000;
    #1;
    check("full_ign_occ", occupancy, 5'b10000);
    check("full_ign_drain_addr", drain_addr, 32'h1000);
    check("full_ign_fwd_hit", fwd_hit, 1'b0);
    fwd_addr = 32'h100C;
    #1;
    check("full_fwd_hit", fwd_hit, 1'b1);
    check("full_fwd_data", fwd_data, 32'hA3);

    // From full: pop fires, push does not.
    set_push(1'b1, 32'h3000, 32'h33, 4'hF);
    drain_ready = 1'b1;
    @(negedge clock);
    check("fullpop_push_ready", push_ready, 1'b0);
    step();
    push_valid  = 1'b0;
    drain_ready = 1'b0;
    fwd_addr    = 32'h3000;
    #1;
    check("fullpop_occ", occupancy, 5'b01000);
    check("fullpop_drain_addr", drain_addr, 32'h1004);
    check("fullpop_no_push", fwd_hit, 1'b0);

    // Push and pop together; tail wraps into entry 0.
    set_push(1'b1, 32'h3000, 32'h33, 4'h5);
    drain_ready = 1'b1;
    step();
    push_valid  = 1'b0;
    drain_ready = 1'b0;
    #1;
    check("pushpop_occ", occupancy, 5'b01000);
    check("pushpop_drain_addr", drain_addr, 32'h1008);
    check("pushpop_fwd_hit", fwd_hit, 1'b1);
    check("pushpop_fwd_data", fwd_data, 32'h33);
    check("pushpop_fwd_mask", fwd_mask, 4'h5);

    // Drain the rest in order, head wrapping through entry 0.
    drain_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("wrap_drain_addr", drain_addr, wrap_order[i]);
      step();
    end
    drain_ready = 1'b0;
    #1;
    check("wrap_empty", empty, 1'b1);
    check("wrap_occ", occupancy, 5'b00001);
    check("wrap_fwd_hit", fwd_hit, 1'b0);

    // Youngest-match forwarding.
    fwd_addr = 32'h102;
    set_push(1'b1, 32'h100, 32'h11, 4'hF);
    step();
    set_push(1'b1, 32'h104, 32'h44, 4'hF);
    step();
    set_push(1'b1, 32'h100, 32'h22, 4'h3);
    step();
    push_valid = 1'b0;
    #1;
    check("fwd_young_hit", fwd_hit, 1'b1);
    check("fwd_young_data", fwd_data, 32'h22);
    check("fwd_young_mask", fwd_mask, 4'h3);
    drain_ready = 1'b1;
    step();
    step();
    drain_ready = 1'b0;
    #1;
    check("fwd_after2_occ", occupancy, 5'b00010);
    check("fwd_after2_drain_data", drain_data, 32'h22);
    check("fwd_after2_hit", fwd_hit, 1'b1);
    check("fwd_after2_data", fwd_data, 32'h22);
    drain_ready = 1'b1;
    @(negedge clock);
    check("fwd_popping_hit", fwd_hit, 1'b1);
    step();
    drain_ready = 1'b0;
    #1;
    check("fwd_gone_hit", fwd_hit, 1'b0);
    check("fwd_gone_empty", empty, 1'b1);

    // A push is not visible to forwarding in its own cycle.
    set_push(1'b1, 32'h200, 32'h55, 4'hF);
    fwd_addr = 32'h200;
    @(negedge clock);
    check("samecyc_hit", fwd_hit, 1'b0);
    step();
    push_valid = 1'b0;
    #1;
    check("nextcyc_hit", fwd_hit, 1'b1);
    check("nextcyc_data", fwd_data, 32'h55);
    drain_ready = 1'b1;
    step();
    drain_ready = 1'b0;
    #1;
    check("samecyc_empty", empty, 1'b1);

    // Asynchronous reset mid-cycle with three entries queued.
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h400 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF);
      step();
    end
    push_valid = 1'b0;
    fwd_addr   = 32'h400;
    #1;
    check("pre_rst_occ", occupancy, 5'b01000);
    check("pre_rst_hit", fwd_hit, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_occ", occupancy, 5'b00001);
    check("async_rst_empty", empty, 1'b1);
    check("async_rst_drain_valid", drain_valid, 1'b0);
    check("async_rst_push_ready", push_ready, 1'b1);
    check("async_rst_fwd_hit", fwd_hit, 1'b0);
    #1 reset = 1'b0;
    step();
    set_push(1'b1, 32'h500, 32'h66, 4'hF);
    step();
    push_valid = 1'b0;
    fwd_addr   = 32'h500;
    #1;
    check("post_rst_occ", occupancy, 5'b00010);
    check("post_rst_drain_valid", drain_valid, 1'b1);
    check("post_rst_drain_addr", drain_addr, 32'h500);
    check("post_rst_drain_data", drain_data, 32'h66);
    check("post_rst_fwd_hit", fwd_hit, 1'b1);
    drain_ready = 1'b1;
    step();
    drain_ready = 1'b0;
    #1;
    check("post_rst_empty", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Circular queue of committed stores between the writeback/commit stage and the data-memory port.
- Accepts one store per cycle, drains the oldest entry to memory over a valid/ready handshake, and offers same-cycle store-to-load forwarding to the memory stage.
- Occupancy is tracked as a one-hot decoded count (bit k set means k entries), the same encoding the CPU's other decoded counters use.
- Drives full/empty back-pressure to the commit stage.

Parameters:
- DEPTH, 4: number of entries; must be at least 2.
- ADDR_W, 32: byte-address width.
- DATA_W, 32: store data width; must be a multiple of 8.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- push_valid  in  1  commit stage presents a store
- push_ready  out  1  buffer can accept a store; equals !full
- push_addr  in  ADDR_W  store byte address
- push_data  in  DATA_W  store data
- push_mask  in  DATA_W/8  byte enables
- drain_valid  out  1  head entry is valid; equals !empty
- drain_ready  in  1  memory port accepts the head entry
- drain_addr  out  ADDR_W  head address
- drain_data  out  DATA_W  head data
- drain_mask  out  DATA_W/8  head byte enables
- fwd_addr  in  ADDR_W  load address to look up
- fwd_hit  out  1  a valid entry matches fwd_addr
- fwd_data  out  DATA_W  data of the youngest matching entry
- fwd_mask  out  DATA_W/8  byte enables of the youngest matching entry
- occupancy  out  DEPTH+1  one-hot entry count
- full  out  1  occupancy[DEPTH]
- empty  out  1  occupancy[0]

Behaviour:
- Reset (asynchronous, active-high):
  - occupancy = 1 (bit 0 set), so empty=1, full=0, push_ready=1, drain_valid=0.
  - Head and tail pointers = one-hot entry 0.
  - All valid bits cleared; fwd_hit=0.
  - Entry payload RAM is not reset; drain_addr, drain_data and drain_mask are don't-care while drain_valid=0.
- Reset asserted mid-operation discards all entries immediately; the first push after deassertion lands in entry 0.
- Push fires on push_valid && push_ready. The entry at tail is written and its valid bit set; tail rotates left by one with wrap (bit DEPTH-1 to bit 0).
- Pop fires on drain_valid && drain_ready. The head valid bit is cleared; head rotates left with wrap.
- Occupancy update, all registered, visible the cycle after the handshake:
  - push only: shift toward MSB.
  - pop only: shift toward LSB.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full: push_ready=0 even if a pop fires in the same cycle; no same-cycle replace. A push_valid while full is ignored and has no state change.
- Empty: drain_valid=0, so a pop cannot fire.
- Latency: a pushed store is presented on drain_* no earlier than the cycle after its push.
- drain_* are combinational from the registered head entry and stay stable while drain_valid && !drain_ready.
- Forwarding is combinational:
  - Match on address bits [ADDR_W-1:log2(DATA_W/8)] against valid entries only.
  - Priority is youngest first, scanning from tail-1 backwards to head.
  - fwd_data and fwd_mask come from that single entry; no byte merging across entries. Masks that only partly cover the load are resolved by the consumer.
  - A push in the same cycle is not visible; an entry being popped in the same cycle is still visible.
- Invariant: occupancy is always exactly one-hot, and its index equals the number of set valid bits.

Decomposition:
- Shared CPU package holds:
  - store_buffer_entry_t struct {addr, data, mask}.
  - Localparam STORE_BUFFER_DEPTH used by the top-level instantiation.
  - Byte-offset width derivation for DATA_W.
- One natural sub-module: onehot_ring_pointer. It holds a DEPTH-bit one-hot register with async reset to bit 0 and an advance input that rotates left with wrap. It is instantiated twice, for head and tail.
- Occupancy uses a one-hot shift register with async reset, coded inline in store_buffer.

Test Plan (DEPTH=4, DATA_W=32):
- Reset release, idle → occupancy=5'b00001, empty=1, push_ready=1, drain_valid=0, fwd_hit=0.
- Push 4 stores A0..A3 with drain_ready=0 → occupancy=5'b10000, full=1, push_ready=0; a 5th push_valid is ignored; drain_addr=A0.
- From full, drain_ready=1 with push_valid=1 → exactly one pop, no push; occupancy=5'b01000. Next cycle, push and pop together → occupancy stays 5'b01000, and head/tail wrap through entry 0.
- Push 0x100/data 0x11, then 0x104, then 0x100/data 0x22, then fwd_addr=0x102 → fwd_hit=1, fwd_data=0x22. After two pops, with 0x100/data 0x22 still queued → still 0x22. After all pops → fwd_hit=0.
- Same cycle: push 0x200 and fwd_addr=0x200 → fwd_hit=0; next cycle → fwd_hit=1.
- Assert reset asynchronously mid-cycle with 3 entries queued → outputs return to reset values before the next clock edge; the next push is drained first and appears on drain_addr.
